// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// Holds the controller state encoding and the iteration counter sizing rule.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

  // The counter must represent 0..len, so it needs clog2(len+1) bits.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/mul_judge.sv
// Result checker for shift_add_multiplier, built only with MUL_JUDGE_EN.
// Mirrors the multiplier's accept/finish handshake, keeps its own copy of the
// operands and raises a sticky error on a wrong product, a finish with no
// outstanding operation, or an operation running past LEN+1 cycles.
module mul_judge #(
  parameter int LEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN-1:0]   multiplicand,
  input  logic [LEN-1:0]   multiplier,
  input  logic             start,
  input  logic [2*LEN-1:0] product,
  input  logic             finish,
  output logic             error
);

  localparam int WW = $clog2(LEN + 2);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(LEN);

  logic             busy;
  logic [LEN-1:0]   a_lat;
  logic [LEN-1:0]   b_lat;
  logic [WW-1:0]    wait_cnt;
  logic [2*LEN-1:0] expected;

  // Full-width reference product of the latched operands.
  assign expected = {{LEN{1'b0}}, a_lat} * {{LEN{1'b0}}, b_lat};

  // Track the outstanding operation and judge each finish pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      error    <= 1'b0;
      a_lat    <= '0;
      b_lat    <= '0;
      wait_cnt <= '0;
    end else begin
      if (finish) begin
        // finish is high exactly in the multiplier's DONE cycle, when start
        // is ignored, so no new operation is latched here.
        if (!busy || product != expected) error <= 1'b1;
        busy <= 1'b0;
      end else if (busy) begin
        if (wait_cnt == WAIT_LIMIT) error <= 1'b1;
        else wait_cnt <= wait_cnt + WW'(1);
      end else if (start) begin
        busy     <= 1'b1;
        a_lat    <= multiplicand;
        b_lat    <= multiplier;
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned LEN x LEN shift-and-add multiplier, 2*LEN-bit product.
// One multiplier bit is consumed per clock; start is accepted in IDLE, finish
// pulses for one cycle LEN edges later, and product holds until the next
// completion.
// Optional feature: define MUL_JUDGE_EN to add the built-in result checker
// (mul_judge) and its sticky error output.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN-1:0]   multiplicand,
  input  logic [LEN-1:0]   multiplier,
  input  logic             start,
  output logic [2*LEN-1:0] product,
  output logic             finish
`ifdef MUL_JUDGE_EN
  ,
  output logic             error
`endif
);

  localparam int CW = cnt_width(LEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(LEN - 1);

  mul_state_t     state;
  logic [LEN-1:0] a_reg;
  logic [2*LEN:0] acc;
  logic [2*LEN:0] acc_next;
  logic [CW-1:0]  cnt;
  logic [LEN:0]   upper_sum;

  // One iteration: conditionally add A into the upper half (carry kept in the
  // extra top bit), then shift the whole accumulator right by one.
  // NOTE: every signal is assigned on every pass through this block, so no
  // latch can be inferred.
  always_comb begin
    upper_sum = acc[2*LEN:LEN] + (acc[0] ? {1'b0, a_reg} : '0);
    acc_next  = {1'b0, upper_sum, acc[LEN-1:1]};
  end

  // Controller and datapath registers: IDLE -> BUSY (LEN edges) -> DONE -> IDLE.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      product <= '0;
      finish  <= 1'b0;
      a_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          finish <= 1'b0;
          if (start) begin
            a_reg <= multiplicand;
            acc   <= {{(LEN + 1){1'b0}}, multiplier};
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            product <= acc_next[2*LEN-1:0];
            finish  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          finish <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          finish <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef MUL_JUDGE_EN
  mul_judge #(
    .LEN(LEN)
  ) u_judge (
    .clk         (clk),
    .rst         (rst),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .start       (start),
    .product     (product),
    .finish      (finish),
    .error       (error)
  );
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (LEN=32). Expected products
// come from plain 64-bit arithmetic; expected timing from the handshake rules
// (finish LEN edges after acceptance, one op every LEN+2 cycles with start held).
module tb_shift_add_multiplier;

  localparam int LEN = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [LEN-1:0]   multiplicand;
  logic [LEN-1:0]   multiplier;
  logic             start;
  logic [2*LEN-1:0] product;
  logic             finish;
`ifdef MUL_JUDGE_EN
  logic             error;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(
    .LEN(LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .start       (start),
    .product     (product),
    .finish      (finish)
`ifdef MUL_JUDGE_EN
    ,
    .error       (error)
`endif
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = 64'(a);
    wb = 64'(b);
    return wa * wb;
  endfunction

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one operation from IDLE; after the accepting edge the operand
  // inputs are replaced by a2/b2. Returns edges-to-finish and the product.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] a2, input logic [31:0] b2,
                       output int lat, output logic [63:0] p);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = a2;
    multiplier   = b2;
    lat = 0;
    while (finish !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = product;
  endtask

  task automatic test_reset();
    int highs;
    apply_reset(2);
    #1;
    checks++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL reset_product got %h want 0", product);
    end
    checks++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL reset_finish got %b want 0", finish);
    end
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      multiplicand = $urandom;
      multiplier   = $urandom;
      if (finish === 1'b1) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL idle_no_finish got %0d pulses want 0", highs);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [63:0] p;
    do_op(32'd20, 32'd40, 32'd20, 32'd40, lat, p);
    checks++;
    if (lat !== LEN) begin
      errors++;
      $display("FAIL basic_latency got %0d want %0d", lat, LEN);
    end
    checks++;
    if (p !== 64'd800) begin
      errors++;
      $display("FAIL basic_product got %0d want 800", p);
    end
    @(posedge clk);
    #1;
    checks++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL basic_finish_width got %b want 0", finish);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (product !== 64'd800) begin
      errors++;
      $display("FAIL basic_product_hold got %0d want 800", product);
    end
  endtask

  task automatic test_back_to_back();
    int fin_edges[$];
    @(negedge clk);
    multiplicand = 32'd20;
    multiplier   = 32'd40;
    start        = 1'b1;
    // Edge 0 accepts; finish becomes visible after edges k*(LEN+2)+LEN.
    for (int e = 0; e < 140; e++) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1) begin
        fin_edges.push_back(e);
        checks++;
        if (product !== 64'd800) begin
          errors++;
          $display("FAIL b2b_product at edge %0d got %0d want 800", e, product);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (fin_edges.size() !== 4) begin
      errors++;
      $display("FAIL b2b_count got %0d want 4", fin_edges.size());
    end
    foreach (fin_edges[k]) begin
      checks++;
      if (fin_edges[k] !== k * (LEN + 2) + LEN) begin
        errors++;
        $display("FAIL b2b_timing pulse %0d got edge %0d want %0d", k, fin_edges[k], k * (LEN + 2) + LEN);
      end
    end
    // Drain the operation accepted after the last observed pulse.
    repeat (40) @(posedge clk);
  endtask

  task automatic test_corners();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [63:0] te [5];
    int lat;
    logic [63:0] p;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; te[0] = 64'hFFFF_FFFE_0000_0001;
    ta[1] = 32'h0;         tb[1] = 32'h1234_5678; te[1] = 64'h0;
    ta[2] = 32'hFFFF_FFFF; tb[2] = 32'h1;         te[2] = 64'h0000_0000_FFFF_FFFF;
    ta[3] = 32'h1;         tb[3] = 32'hFFFF_FFFF; te[3] = 64'h0000_0000_FFFF_FFFF;
    ta[4] = 32'h8000_0000; tb[4] = 32'h2;         te[4] = 64'h0000_0001_0000_0000;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], ta[i], tb[i], lat, p);
      checks++;
      if (p !== te[i]) begin
        errors++;
        $display("FAIL corner_product %h x %h got %h want %h", ta[i], tb[i], p, te[i]);
      end
      checks++;
      if (lat !== LEN) begin
        errors++;
        $display("FAIL corner_latency %h x %h got %0d want %0d", ta[i], tb[i], lat, LEN);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_operand_change();
    int lat;
    logic [63:0] p;
    do_op(32'd7, 32'd9, 32'h0000_FFFF, 32'h0000_FFFF, lat, p);
    checks++;
    if (p !== 64'd63) begin
      errors++;
      $display("FAIL operand_change got %0d want 63", p);
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    int lat;
    logic [63:0] p;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = a >> $urandom_range(31, 0);
      do_op(a, b, $urandom, $urandom, lat, p);
      checks++;
      if (p !== ref_mul(a, b) || lat !== LEN) begin
        errors++;
        $display("FAIL random %h x %h got %h lat %0d want %h lat %0d", a, b, p, lat, ref_mul(a, b), LEN);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int highs;
    int lat;
    logic [63:0] p;
    @(negedge clk);
    multiplicand = 32'd123;
    multiplier   = 32'd456;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL abort_no_finish got %0d pulses want 0", highs);
    end
    checks++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL abort_product got %h want 0", product);
    end
    do_op(32'd3, 32'd5, 32'd3, 32'd5, lat, p);
    checks++;
    if (p !== 64'd15 || lat !== LEN) begin
      errors++;
      $display("FAIL after_abort got %0d lat %0d want 15 lat %0d", p, lat, LEN);
    end
    @(posedge clk);
  endtask

`ifdef MUL_JUDGE_EN
  task automatic test_judge();
    int lat;
    logic [63:0] p;
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL judge_clean got %b want 0", error);
    end
    do_op(32'd6, 32'd7, 32'd6, 32'd7, lat, p);
    force dut.product = 64'd43;
    @(posedge clk);
    #1;
    release dut.product;
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL judge_detect got %b want 1", error);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL judge_sticky got %b want 1", error);
    end
    apply_reset(2);
    #1;
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL judge_clear got %b want 0", error);
    end
  endtask
`endif

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_corners();
    test_operand_change();
    test_random();
    test_reset_mid();
`ifdef MUL_JUDGE_EN
    test_judge();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
